// File: rtl/pll_phase_step_responder_if.sv
// Phase-shift handshake between a controller and the PLL-side responder.
// Ports: phase_en, updn, cntsel (controller->PLL), phase_done (PLL->controller).
interface pll_phase_step_responder_if;
    logic       phase_en;
    logic       updn;
    logic [4:0] cntsel;
    logic       phase_done;

    modport master (
        output phase_en,
        output updn,
        output cntsel,
        input  phase_done
    );

    modport slave (
        input  phase_en,
        input  updn,
        input  cntsel,
        output phase_done
    );
endinterface

// File: rtl/pll_phase_step_responder.sv
// PLL dynamic phase-shift responder: answers phase_en/updn/cntsel with
// phase_done like the fractional PLL and tracks per-counter phase offsets.
// Ports: scanclk, rst_n (async low), locked, ps (slave handshake),
//        phase_offset (packed C0..Cn-1), busy, shift_count (saturating), err.
module pll_phase_step_responder #(
    parameter int NUM_COUNTERS = 3,
    parameter int PHASE_STEPS  = 8,
    parameter int PHASE_W      = 3,
    parameter int SHIFT_CYCLES = 4,
    parameter int MIN_EN       = 2
) (
    input  logic                            scanclk,
    input  logic                            rst_n,
    input  logic                            locked,
    pll_phase_step_responder_if.slave       ps,
    output logic [NUM_COUNTERS*PHASE_W-1:0] phase_offset,
    output logic                            busy,
    output logic [15:0]                     shift_count,
    output logic                            err
);

    localparam int OW = NUM_COUNTERS * PHASE_W;
    localparam int EW = $clog2(MIN_EN + 1);
    localparam int SW = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;

    localparam logic [EW-1:0]      EN_MIN  = EW'(MIN_EN);
    localparam logic [EW-1:0]      EN_ONE  = EW'(1);
    localparam logic [SW-1:0]      SH_LAST = SW'(SHIFT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PS_MAX  = PHASE_W'(PHASE_STEPS - 1);
    localparam logic [4:0]         SEL_ALL = 5'h1F;
    localparam logic [4:0]         SEL_NC  = 5'(NUM_COUNTERS);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT,
        ACK
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] en_cnt_q, en_cnt_d;
    logic [SW-1:0] sh_cnt_q, sh_cnt_d;
    logic [4:0]    cntsel_q, cntsel_d;
    logic          updn_q, updn_d;
    logic [OW-1:0] offset_q, offset_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [15:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          locked_q;

    logic [EW-1:0] en_inc;
    logic          sel_all;
    logic          sel_ok;

    // Offsets wrap modulo PHASE_STEPS, which need not be a power of two.
    function automatic logic [PHASE_W-1:0] step_off(
        input logic [PHASE_W-1:0] v,
        input logic               up
    );
        if (up) begin
            return (v == PS_MAX) ? '0 : v + 1'b1;
        end
        return (v == '0) ? PS_MAX : v - 1'b1;
    endfunction

    assign en_inc  = en_cnt_q + EN_ONE;
    assign sel_all = (cntsel_q == SEL_ALL);
    assign sel_ok  = sel_all || (cntsel_q < SEL_NC);

    always_comb begin
        state_d  = state_q;
        en_cnt_d = en_cnt_q;
        sh_cnt_d = sh_cnt_q;
        cntsel_d = cntsel_q;
        updn_d   = updn_q;
        offset_d = offset_q;
        done_d   = done_q;
        count_d  = count_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (locked && ps.phase_en) begin
                    cntsel_d = ps.cntsel;
                    updn_d   = ps.updn;
                    en_cnt_d = EN_ONE;
                    sh_cnt_d = '0;
                    if (MIN_EN == 1) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end

            ARMED: begin
                if (!locked) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (ps.phase_en) begin
                    en_cnt_d = en_inc;
                    if (en_inc == EN_MIN) begin
                        state_d  = SHIFT;
                        sh_cnt_d = '0;
                    end
                end else begin
                    // Runt pulse: request withdrawn too early.
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end

            SHIFT: begin
                if (!locked) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (sh_cnt_q == SH_LAST) begin
                    state_d = ACK;
                    done_d  = 1'b0;
                    if (sel_ok) begin
                        for (int k = 0; k < NUM_COUNTERS; k++) begin
                            if (sel_all || (cntsel_q == 5'(k))) begin
                                offset_d[k*PHASE_W +: PHASE_W] =
                                    step_off(offset_q[k*PHASE_W +: PHASE_W],
                                             updn_q);
                            end
                        end
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                    end else begin
                        // Bad select still completes the handshake.
                        err_d = 1'b1;
                    end
                end else begin
                    sh_cnt_d = sh_cnt_q + 1'b1;
                end
            end

            ACK: begin
                if (!locked) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (!ps.phase_en) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        endcase

        // A falling edge of lock wipes every offset regardless of state.
        if (locked_q && !locked) begin
            offset_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge scanclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            en_cnt_q <= '0;
            sh_cnt_q <= '0;
            cntsel_q <= '0;
            updn_q   <= 1'b0;
            offset_q <= '0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_cnt_q <= en_cnt_d;
            sh_cnt_q <= sh_cnt_d;
            cntsel_q <= cntsel_d;
            updn_q   <= updn_d;
            offset_q <= offset_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
            err_q    <= err_d;
            locked_q <= locked;
        end
    end

    assign ps.phase_done = done_q;
    assign phase_offset  = offset_q;
    assign busy          = busy_q;
    assign shift_count   = count_q;
    assign err           = err_q;

endmodule

// File: tb/tb_pll_phase_step_responder.sv
// Directed bench for pll_phase_step_responder: an 8-step and a 5-step
// instance run in lockstep against a queued reference model.
module tb_pll_phase_step_responder;

    logic clk = 1'b0;
    logic rst_n;
    logic locked;

    always #5 clk = ~clk;

    pll_phase_step_responder_if bus8 ();
    pll_phase_step_responder_if bus5 ();

    logic [8:0]  off8, off5;
    logic        busy8, busy5, err8, err5;
    logic [15:0] cnt8, cnt5;

    pll_phase_step_responder dut8 (
        .scanclk      (clk),
        .rst_n        (rst_n),
        .locked       (locked),
        .ps           (bus8.slave),
        .phase_offset (off8),
        .busy         (busy8),
        .shift_count  (cnt8),
        .err          (err8)
    );

    pll_phase_step_responder #(
        .PHASE_STEPS (5),
        .PHASE_W     (3)
    ) dut5 (
        .scanclk      (clk),
        .rst_n        (rst_n),
        .locked       (locked),
        .ps           (bus5.slave),
        .phase_offset (off5),
        .busy         (busy5),
        .shift_count  (cnt5),
        .err          (err5)
    );

    typedef struct {
        logic [8:0]  o8;
        logic [8:0]  o5;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   m8[3];
    int   m5[3];
    int   mcnt;
    logic merr;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] pack8();
        return {3'(m8[2]), 3'(m8[1]), 3'(m8[0])};
    endfunction

    function automatic logic [8:0] pack5();
        return {3'(m5[2]), 3'(m5[1]), 3'(m5[0])};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m8[k] = 0;
            m5[k] = 0;
        end
    endtask

    task automatic model_apply(input int sel, input bit up);
        if (sel == 31 || sel < 3) begin
            for (int k = 0; k < 3; k++) begin
                if (sel == 31 || sel == k) begin
                    m8[k] = up ? (m8[k] + 1) % 8 : (m8[k] + 7) % 8;
                    m5[k] = up ? (m5[k] + 1) % 5 : (m5[k] + 4) % 5;
                end
            end
            mcnt++;
        end else begin
            merr = 1'b1;
        end
    endtask

    task automatic drv(input logic en, input logic up, input logic [4:0] sel);
        bus8.phase_en = en;
        bus8.updn     = up;
        bus8.cntsel   = sel;
        bus5.phase_en = en;
        bus5.updn     = up;
        bus5.cntsel   = sel;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, " off8"}, 32'(off8), 32'(pack8()));
        chk({tag, " off5"}, 32'(off5), 32'(pack5()));
        chk({tag, " cnt8"}, 32'(cnt8), 32'(mcnt));
        chk({tag, " cnt5"}, 32'(cnt5), 32'(mcnt));
        chk({tag, " err8"}, 32'(err8), 32'(merr));
        chk({tag, " err5"}, 32'(err5), 32'(merr));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " done8"}, 32'(bus8.phase_done), 32'd1);
        chk({tag, " done5"}, 32'(bus5.phase_done), 32'd1);
        chk({tag, " off8"}, 32'(off8), 32'd0);
        chk({tag, " off5"}, 32'(off5), 32'd0);
        chk({tag, " busy8"}, 32'(busy8), 32'd0);
        chk({tag, " busy5"}, 32'(busy5), 32'd0);
        chk({tag, " cnt8"}, 32'(cnt8), 32'd0);
        chk({tag, " err8"}, 32'(err8), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals(tag);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        mcnt = 0;
        merr = 1'b0;
    endtask

    // Full request: phase_en held until phase_done falls, then dropped.
    // cntsel/updn are scrambled after the latch to prove they are ignored.
    task automatic do_shift(input string tag, input int sel, input bit up);
        exp_t e;
        int   n;
        bit   got;
        model_apply(sel, up);
        e.o8  = pack8();
        e.o5  = pack5();
        e.cnt = 16'(mcnt);
        e.err = merr;
        sb.push_back(e);

        drv(1'b1, up, 5'(sel));
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                drv(1'b1, ~up, ~5'(sel));
            end
            if (bus8.phase_done === 1'b0) begin
                got = 1'b1;
            end
        end
        chk({tag, " done edge"}, got ? 32'(n - 1) : 32'd999, 32'd5);
        chk({tag, " done5 low"}, 32'(bus5.phase_done), 32'd0);
        chk({tag, " busy"}, 32'(busy8), 32'd1);

        e = sb.pop_front();
        chk({tag, " off8"}, 32'(off8), 32'(e.o8));
        chk({tag, " off5"}, 32'(off5), 32'(e.o5));
        chk({tag, " cnt"}, 32'(cnt8), 32'(e.cnt));
        chk({tag, " err"}, 32'(err8), 32'(e.err));

        drv(1'b0, up, 5'(sel));
        @(negedge clk);
        chk({tag, " done rise"}, 32'(bus8.phase_done), 32'd1);
        chk({tag, " done5 rise"}, 32'(bus5.phase_done), 32'd1);
        chk({tag, " idle"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  got;
        bit  stayed;

        rst_n  = 1'b0;
        locked = 1'b1;
        drv(1'b0, 1'b0, 5'd0);
        model_clear();
        mcnt = 0;
        merr = 1'b0;

        do_reset("reset");

        // Single up-shift on C1, then an invalid select on the same run.
        do_shift("up_c1", 1, 1'b1);
        chk("up_c1 field", 32'(off8[5:3]), 32'd1);
        do_shift("bad_sel", 5, 1'b1);

        // Runt pulse: one sampled-high cycle only.
        do_reset("reset2");
        drv(1'b1, 1'b1, 5'd0);
        @(negedge clk);
        chk("runt armed busy", 32'(busy8), 32'd1);
        chk("runt armed done", 32'(bus8.phase_done), 32'd1);
        drv(1'b0, 1'b1, 5'd0);
        @(negedge clk);
        merr = 1'b1;
        chk("runt busy", 32'(busy8), 32'd0);
        chk("runt done", 32'(bus8.phase_done), 32'd1);
        chk_state("runt");
        @(negedge clk);
        chk("runt done hold", 32'(bus8.phase_done), 32'd1);

        // All-counter down-shift from zero.
        do_reset("reset3");
        do_shift("all_dn", 31, 1'b0);
        chk("all_dn off8", 32'(off8), 32'h1FF);
        chk("all_dn off5", 32'(off5), 32'h124);

        // Lock drop in IDLE clears offsets without an error.
        @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        @(negedge clk);
        model_clear();
        chk_state("lock_clr");

        // Wrap both ways on C0 in both instances.
        for (int i = 0; i < 10; i++) begin
            do_shift("wrap_up", 0, 1'b1);
        end
        chk("wrap_up c0_8", 32'(off8[2:0]), 32'd2);
        chk("wrap_up c0_5", 32'(off5[2:0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            do_shift("wrap_dn", 0, 1'b0);
        end
        chk("wrap_dn c0_8", 32'(off8[2:0]), 32'd7);
        chk("wrap_dn c0_5", 32'(off5[2:0]), 32'd2);

        // Lock loss while in SHIFT.
        drv(1'b1, 1'b1, 5'd0);
        stayed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus8.phase_done !== 1'b1) stayed = 1'b0;
        end
        locked = 1'b0;
        @(negedge clk);
        if (bus8.phase_done !== 1'b1) stayed = 1'b0;
        model_clear();
        merr = 1'b1;
        chk("lockloss done held", 32'(stayed), 32'd1);
        chk("lockloss busy", 32'(busy8), 32'd0);
        chk_state("lockloss");
        drv(1'b0, 1'b1, 5'd0);
        locked = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset asserted while in ACK.
        drv(1'b1, 1'b1, 5'd2);
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if (bus8.phase_done === 1'b0) got = 1'b1;
        end
        chk("ack reached", 32'(got), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_in_ack");
        drv(1'b0, 1'b0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("sb empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
